mac_stream_feeder: RTL and testbench

- Drives one mac_wrapper instance, which registers a, b and c once, then computes out = c + sum of a[i]*b[i] combinationally.
- Accepts a stream of 4-lane activation/weight chunks over valid/ready and presents them to the wrapper, one chunk per cycle at full rate.
- Closes the partial-sum loop by steering the wrapper's out back into its c input.
- Captures the final dot product of each vector and returns it over a valid/ready result interface.

---
 rtl/mac_stream_feeder.sv | 198 +++++++++++++++++++
 tb/tb_mac_stream_feeder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_feeder.sv
// -----------------------------------------------------------------------------
// mac_stream_feeder
//
// Feeds a stream of 4-lane activation/weight chunks into one mac_wrapper and
// returns the finished dot product of each vector.
//
// mac_wrapper registers a, b and c once, then computes
// out = c + sum(a[i]*b[i]) combinationally. This block closes the
// partial-sum loop by steering mac_out back into c. The first chunk of every
// vector is forced to see c = 0. Because the wrapper registers c, the feedback
// path contains no combinational loop.
//
// Handshakes (both interfaces): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds its data stable while valid
// is high and ready is low. in_ready depends only on the FSM state, never on
// in_valid. out_valid/out_data/out_cnt are held stable until out_ready is seen.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   in_a       activation chunk, lanes [3:0], bw bits each
//   in_b       weight chunk, lanes [3:0], bw bits each
//   in_last    marks the final chunk of a vector
//   in_valid   chunk valid
//   in_ready   feeder accepts a chunk this cycle
//   mac_a      to mac_wrapper a (registered, zero on non-accept cycles)
//   mac_b      to mac_wrapper b (registered, zero on non-accept cycles)
//   mac_c      to mac_wrapper c (0 for a vector's first chunk, else mac_out)
//   mac_out    from mac_wrapper out
//   out_data   final dot product (mac_out bit-exact)
//   out_cnt    number of chunks in the vector, saturating
//   out_valid  result valid
//   out_ready  result consumer ready
//   dbg_state  current FSM state (IDLE=0, ACC=1, DRAIN1=2, DRAIN2=3, DONE=4)
// -----------------------------------------------------------------------------
module mac_stream_feeder #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*bw-1:0]     in_a,
    input  logic [4*bw-1:0]     in_b,
    input  logic                in_last,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*bw-1:0]     mac_a,
    output logic [4*bw-1:0]     mac_b,
    output logic [psum_bw-1:0]  mac_c,
    input  logic [psum_bw-1:0]  mac_out,
    output logic [psum_bw-1:0]  out_data,
    output logic [cnt_bw-1:0]   out_cnt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC    = 3'd1,
        DRAIN1 = 3'd2,
        DRAIN2 = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [cnt_bw-1:0] cnt_max = '1;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                first_accept;
    logic                capture;
    logic                release_out;
    logic                first_q;
    logic [cnt_bw-1:0]   chunk_cnt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-state controls
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = in_last ? DRAIN1 : ACC;
                end
            end
            ACC: begin
                // Gaps inside a vector are allowed indefinitely.
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_next = DRAIN1;
                end
            end
            DRAIN1: begin
                // The wrapper captures the last chunk on this edge.
                state_next = DRAIN2;
            end
            DRAIN2: begin
                // mac_out now holds the complete dot product.
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept       = in_valid && in_ready;
    assign first_accept = accept && (state == IDLE);
    assign dbg_state    = state;

    // ------------------------------------------------------------------
    // Operand registers. Non-accept cycles load zero so that idle cycles
    // add a zero product while c = mac_out keeps the partial sum alive.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_a <= '0;
            mac_b <= '0;
        end else if (accept) begin
            mac_a <= in_a;
            mac_b <= in_b;
        end else begin
            mac_a <= '0;
            mac_b <= '0;
        end
    end

    // ------------------------------------------------------------------
    // first_q is high during the cycle in which a vector's first chunk is
    // presented on mac_a/mac_b, so the wrapper registers c = 0 alongside it
    // and no result leaks into the next vector.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q <= 1'b1;
        end else begin
            first_q <= first_accept;
        end
    end

    assign mac_c = first_q ? '0 : mac_out;

    // ------------------------------------------------------------------
    // Chunk counter, saturating at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chunk_cnt <= '0;
        end else if (first_accept) begin
            chunk_cnt <= cnt_bw'(1);
        end else if (accept && (chunk_cnt != cnt_max)) begin
            chunk_cnt <= chunk_cnt + cnt_bw'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result registers: loaded from mac_out in DRAIN2, held through DONE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            out_data  <= mac_out;
            out_cnt   <= chunk_cnt;
            out_valid <= 1'b1;
        end else if (release_out) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_stream_feeder.sv
// -----------------------------------------------------------------------------
// tb_mac_stream_feeder
//
// Two feeders share one input stream: dut0 with the default 8-bit counter and
// dut1 with a 2-bit counter (saturation at 3). Each drives its own mac_wrapper
// model. A vector-level reference model (running dot products, a queue of
// expected results, edge counts since the last accept) is checked against both
// DUTs every cycle; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_mac_stream_feeder;

  logic        clk;
  logic        reset;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready0, out_valid0;
  logic [15:0] mac_a0, mac_b0, mac_c0, mac_out0, out_data0;
  logic [7:0]  out_cnt0;
  logic [2:0]  dbg0;

  logic        in_ready1, out_valid1;
  logic [15:0] mac_a1, mac_b1, mac_c1, mac_out1, out_data1;
  logic [1:0]  out_cnt1;
  logic [2:0]  dbg1;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  mac_stream_feeder #(.bw(4), .psum_bw(16), .cnt_bw(8)) dut0 (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready0), .mac_a(mac_a0), .mac_b(mac_b0),
    .mac_c(mac_c0), .mac_out(mac_out0), .out_data(out_data0), .out_cnt(out_cnt0),
    .out_valid(out_valid0), .out_ready(out_ready), .dbg_state(dbg0)
  );

  mac_stream_feeder #(.bw(4), .psum_bw(16), .cnt_bw(2)) dut1 (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready1), .mac_a(mac_a1), .mac_b(mac_b1),
    .mac_c(mac_c1), .mac_out(mac_out1), .out_data(out_data1), .out_cnt(out_cnt1),
    .out_valid(out_valid1), .out_ready(out_ready), .dbg_state(dbg1)
  );

  function automatic logic [15:0] dot(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s = s + 16'(a[4*i +: 4]) * 16'(b[4*i +: 4]);
    return s;
  endfunction

  function automatic int sat(input int n, input int m);
    return (n > m) ? m : n;
  endfunction

  // ---------------- mac_wrapper models (environment) ----------------
  logic [15:0] w0_a, w0_b, w0_c, w1_a, w1_b, w1_c;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w0_a <= '0; w0_b <= '0; w0_c <= '0;
      w1_a <= '0; w1_b <= '0; w1_c <= '0;
    end else begin
      w0_a <= mac_a0; w0_b <= mac_b0; w0_c <= mac_c0;
      w1_a <= mac_a1; w1_b <= mac_b1; w1_c <= mac_c1;
    end
  end
  assign mac_out0 = w0_c + dot(w0_a, w0_b);
  assign mac_out1 = w1_c + dot(w1_a, w1_b);

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT did not respond within the cycle budget at %0t", name, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [15:0] exp_q[$];     // expected dot product per finished vector
  int          exp_n_q[$];   // chunk count per finished vector
  bit          prev_acc;     // the last edge accepted a chunk
  logic [15:0] prev_a, prev_b, prev_c;
  logic [15:0] run_sum;
  int          run_n;
  bit          in_vec;
  int          since;        // edges since the last chunk of the pending vector

  function automatic void model_clear();
    exp_q.delete();
    exp_n_q.delete();
    prev_acc = 0;
    prev_a = '0; prev_b = '0; prev_c = '0;
    run_sum = '0; run_n = 0; in_vec = 0; since = 0;
  endfunction

  function automatic void model_step();
    bit pending;
    pending = (exp_q.size() != 0);
    prev_acc = 0;
    if (pending) begin
      if (since >= 2 && out_ready) begin
        void'(exp_q.pop_front());
        void'(exp_n_q.pop_front());
      end else if (since < 2) begin
        since++;
      end
    end else if (in_valid) begin
      prev_acc = 1;
      prev_a = in_a;
      prev_b = in_b;
      if (!in_vec) begin
        run_sum = '0;
        run_n = 0;
      end
      prev_c = run_sum;
      run_sum = run_sum + dot(in_a, in_b);
      run_n++;
      in_vec = 1;
      if (in_last) begin
        exp_q.push_back(run_sum);
        exp_n_q.push_back(run_n);
        since = 0;
        in_vec = 0;
      end
    end
  endfunction

  task automatic check_cycle();
    bit pending, exp_valid;
    logic [15:0] ea, eb;
    pending = (exp_q.size() != 0);
    exp_valid = pending && (since >= 2);
    ea = prev_acc ? prev_a : 16'd0;
    eb = prev_acc ? prev_b : 16'd0;
    chk("in_ready0", 32'(in_ready0), 32'(!pending));
    chk("in_ready1", 32'(in_ready1), 32'(!pending));
    chk("out_valid0", 32'(out_valid0), 32'(exp_valid));
    chk("out_valid1", 32'(out_valid1), 32'(exp_valid));
    chk("mac_a0", 32'(mac_a0), 32'(ea));
    chk("mac_b0", 32'(mac_b0), 32'(eb));
    chk("mac_a1", 32'(mac_a1), 32'(ea));
    chk("mac_b1", 32'(mac_b1), 32'(eb));
    if (prev_acc) begin
      chk("mac_c0", 32'(mac_c0), 32'(prev_c));
      chk("mac_c1", 32'(mac_c1), 32'(prev_c));
    end
    if (exp_valid) begin
      chk("out_data0", 32'(out_data0), 32'(exp_q[0]));
      chk("out_data1", 32'(out_data1), 32'(exp_q[0]));
      chk("out_cnt0", 32'(out_cnt0), 32'(sat(exp_n_q[0], 255)));
      chk("out_cnt1", 32'(out_cnt1), 32'(sat(exp_n_q[0], 3)));
    end
  endtask

  // Compare process: model advances on each rising edge, DUTs are checked
  // on the following falling edge.
  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (reset) model_clear();
      else model_step();
      @(negedge clk);
      check_cycle();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      in_last = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  // Presents one chunk until accepted; returns mac_c seen in its issue cycle.
  task automatic send_chunk(input logic [15:0] a, input logic [15:0] b,
                            input logic last, output logic [15:0] c_issue);
    int w;
    bit r;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    w = 0; r = 0;
    while (!r) begin
      @(negedge clk);
      r = in_ready0;
      tick();
      if (!r) begin
        w++;
        if (w > 300) begin
          fail_now("send_timeout");
          break;
        end
      end
    end
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_last = 1'($urandom_range(0, 1));
    c_issue = mac_c0;
  endtask

  // Waits for a result, checks it against literals, optionally stalls the
  // consumer for `hold` cycles, then completes the handshake.
  task automatic get_result(input string tag, input logic [15:0] exp_d,
                            input int exp_c0, input int exp_c1, input int hold);
    int w;
    out_ready = (hold == 0);
    w = 0;
    @(negedge clk);
    while (!out_valid0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid0) begin
      fail_now({tag, "_timeout"});
      out_ready = 1'b1;
      tick();
      return;
    end
    chk({tag, "_data0"}, 32'(out_data0), 32'(exp_d));
    chk({tag, "_data1"}, 32'(out_data1), 32'(exp_d));
    chk({tag, "_cnt0"}, 32'(out_cnt0), 32'(exp_c0));
    chk({tag, "_cnt1"}, 32'(out_cnt1), 32'(exp_c1));
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_valid"}, 32'(out_valid0), 32'd1);
      chk({tag, "_hold_data"}, 32'(out_data0), 32'(exp_d));
      chk({tag, "_hold_in_ready"}, 32'(in_ready0), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] c;
  int len, w;

  initial begin
    reset = 1'b1;
    in_a = '0; in_b = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mac_a", 32'(mac_a0), 32'd0);
    chk("rst_mac_c", 32'(mac_c0), 32'd0);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_out_data", 32'(out_data0), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt0), 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_state", 32'(dbg0), 32'd0);
    #2 reset = 1'b0;
    tick();
    out_ready = 1'b1;

    // 1: single chunk vector
    send_chunk(16'h4321, 16'h1111, 1'b1, c);
    chk("s1_issue_c", 32'(c), 32'd0);
    get_result("s1", 16'd10, 1, 1, 0);
    chk("s1_in_ready_after", 32'(in_ready0), 32'd1);

    // 2: three back-to-back chunks
    send_chunk(16'h1111, 16'h2222, 1'b0, c);
    chk("s2_c_chunk1", 32'(c), 32'd0);
    send_chunk(16'h1111, 16'h2222, 1'b0, c);
    chk("s2_c_chunk2", 32'(c), 32'd8);
    send_chunk(16'h1111, 16'h2222, 1'b1, c);
    chk("s2_c_chunk3", 32'(c), 32'd16);
    chk("s2_model", 32'(exp_q[0]), 32'd24);
    get_result("s2", 16'd24, 3, 3, 0);

    // 3: same vector with input gaps
    send_chunk(16'h1111, 16'h2222, 1'b0, c);
    idle(3);
    chk("s3_gap1_mac_out", 32'(mac_out0), 32'd8);
    chk("s3_gap1_mac_a", 32'(mac_a0), 32'd0);
    send_chunk(16'h1111, 16'h2222, 1'b0, c);
    chk("s3_c_chunk2", 32'(c), 32'd8);
    idle(2);
    chk("s3_gap2_mac_out", 32'(mac_out0), 32'd16);
    send_chunk(16'h1111, 16'h2222, 1'b1, c);
    chk("s3_c_chunk3", 32'(c), 32'd16);
    get_result("s3", 16'd24, 3, 3, 0);

    // 4: consumer stalls, then a fresh vector must not inherit the result
    send_chunk(16'h4321, 16'h1111, 1'b1, c);
    get_result("s4a", 16'd10, 1, 1, 5);
    send_chunk(16'h1111, 16'h1111, 1'b1, c);
    chk("s4b_issue_c", 32'(c), 32'd0);
    get_result("s4b", 16'd4, 1, 1, 0);

    // 5: asynchronous reset mid-vector
    send_chunk(16'h1111, 16'h2222, 1'b0, c);
    send_chunk(16'h1111, 16'h2222, 1'b0, c);
    #2 reset = 1'b1;
    #1;
    chk("s5_mac_a", 32'(mac_a0), 32'd0);
    chk("s5_mac_b", 32'(mac_b0), 32'd0);
    chk("s5_mac_c", 32'(mac_c0), 32'd0);
    chk("s5_out_valid", 32'(out_valid0), 32'd0);
    chk("s5_in_ready", 32'(in_ready0), 32'd1);
    chk("s5_state", 32'(dbg0), 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    tick();
    send_chunk(16'h4321, 16'h1111, 1'b1, c);
    get_result("s5", 16'd10, 1, 1, 0);

    // 5b: asynchronous reset while a result is waiting
    send_chunk(16'h4321, 16'h1111, 1'b1, c);
    out_ready = 1'b0;
    w = 0;
    @(negedge clk);
    while (!out_valid0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid0) fail_now("s5b_timeout");
    #2 reset = 1'b1;
    #1;
    chk("s5b_out_valid0", 32'(out_valid0), 32'd0);
    chk("s5b_out_valid1", 32'(out_valid1), 32'd0);
    chk("s5b_out_data", 32'(out_data0), 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    tick();
    out_ready = 1'b1;

    // 6: five chunks, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) send_chunk(16'h1000, 16'h1000, (i == 4), c);
    get_result("s6", 16'd5, 5, 3, 0);

    // Randomized vectors with random gaps and consumer back-pressure;
    // one long vector exercises 8-bit counter saturation.
    rand_ready = 1;
    for (int v = 0; v < 40; v++) begin
      len = (v == 20) ? 300 : $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        send_chunk(16'($urandom), 16'($urandom), (k == len - 1), c);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end
    rand_ready = 0;
    out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      tick();
      w++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    idle(2);
    chk("end_in_ready", 32'(in_ready0), 32'd1);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
